// File: rtl/mont_exp_sequencer.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// Sequences an external Montgomery multiplier; owns no arithmetic itself.
module mont_exp_sequencer #(
    parameter int N     = 512,
    parameter int EXP_W = 512,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             mont_only,
    input  logic [N-1:0]     modulus,
    input  logic [N-1:0]     r_mod_m,
    input  logic [N-1:0]     r2_mod_m,
    input  logic [EXP_W-1:0] exponent,
    input  logic [N-1:0]     x,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     result,
    output logic             mul_start,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    output logic [N-1:0]     mul_m,
    input  logic             mul_done,
    input  logic [N-1:0]     mul_result
);

    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_MONO, S_TOMONT, S_SQR, S_MUL, S_NEXT, S_FROMMONT, S_FIN
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_xm;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_rm;
    logic [EXP_W-1:0] r_exp;
    logic [CNT_W-1:0] r_idx;
    logic             w_bit;

    assign w_bit = r_exp[r_idx[IW-1:0]];

    // Sequencer: operands for each product are loaded together with its mul_start pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_xm      <= {N{1'b0}};
            r_acc     <= {N{1'b0}};
            r_rm      <= {N{1'b0}};
            r_exp     <= {EXP_W{1'b0}};
            r_idx     <= {CNT_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= {N{1'b0}};
            mul_start <= 1'b0;
            mul_a     <= {N{1'b0}};
            mul_b     <= {N{1'b0}};
            mul_m     <= {N{1'b0}};
        end else begin
            mul_start <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        mul_m     <= modulus;
                        r_rm      <= r_mod_m;
                        r_exp     <= exponent;
                        mul_a     <= x;
                        mul_b     <= r2_mod_m;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= mont_only ? S_MONO : S_TOMONT;
                    end
                end
                S_MONO, S_FROMMONT: begin
                    if (mul_done) begin
                        result  <= mul_result;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FIN;
                    end
                end
                S_TOMONT: begin
                    if (mul_done) begin
                        r_xm      <= mul_result;
                        r_acc     <= r_rm;
                        r_idx     <= CNT_W'(EXP_W - 1);
                        mul_a     <= r_rm;
                        mul_b     <= r_rm;
                        mul_start <= 1'b1;
                        r_state   <= S_SQR;
                    end
                end
                S_SQR: begin
                    if (mul_done) begin
                        r_acc <= mul_result;
                        if (w_bit) begin
                            mul_a     <= mul_result;
                            mul_b     <= r_xm;
                            mul_start <= 1'b1;
                            r_state   <= S_MUL;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        r_acc   <= mul_result;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // Multiplying by plain 1 strips the Montgomery factor on the way out.
                    if (r_idx == {CNT_W{1'b0}}) begin
                        mul_a     <= r_acc;
                        mul_b     <= ONE;
                        mul_start <= 1'b1;
                        r_state   <= S_FROMMONT;
                    end else begin
                        r_idx     <= r_idx - {{(CNT_W-1){1'b0}}, 1'b1};
                        mul_a     <= r_acc;
                        mul_b     <= r_acc;
                        mul_start <= 1'b1;
                        r_state   <= S_SQR;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
